// File: rtl/fixed_mult_pipe_pkg.sv
// Shared types and constants for the pipelined fixed-point multiplier.
package fixed_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;

    // Q16.16 word used by the AM receiver datapath
    typedef logic signed [31:0] q16_16_t;

    // Largest positive two's complement value of w bits, as a raw pattern
    function automatic logic [63:0] sat_max(input int w);
        sat_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of w bits, as a raw w-bit pattern
    function automatic logic [63:0] sat_min(input int w);
        sat_min = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_mult_pipe_if.sv
// Operand/result handshake bundle between the mixer/NCO stage, the multiplier
// and the low-pass filter.
interface fixed_mult_pipe_if
    import fixed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             ovf;

    // Upstream/downstream side: supplies operands, consumes results
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, ovf
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/fixed_mult_pipe_round_sat.sv
// Combinational rescale of a full-width signed product back to the Q format:
// optional round half toward +inf, arithmetic shift, overflow detect and
// optional saturation.
module fixed_round_sat
    import fixed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter bit ROUND = 1'b1,
    parameter bit SAT   = 1'b1
) (
    input  logic signed [2*WIDTH-1:0] p,
    output logic        [WIDTH-1:0]   y,
    output logic                      ovf
);
    // One guard bit above the product so the rounding add cannot wrap
    localparam int PG = 2*WIDTH + 1;
    localparam logic [PG-1:0]    RND  = ROUND ? (PG'(1) << (FRAC - 1)) : '0;
    localparam logic [WIDTH-1:0] YMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] YMIN = WIDTH'(sat_min(WIDTH));

    logic signed [PG-1:0] pg;
    logic signed [PG-1:0] r;
    logic                 in_range;

    // Round, rescale, then range-check: r fits iff all bits from WIDTH-1 up agree
    always_comb begin
        pg       = {p[2*WIDTH-1], p} + RND;
        r        = pg >>> FRAC;
        in_range = (&r[PG-1:WIDTH-1]) | ~(|r[PG-1:WIDTH-1]);
        ovf      = ~in_range;
        y        = r[WIDTH-1:0];
        if (ovf && SAT)
            y = r[PG-1] ? YMIN : YMAX;
    end
endmodule

// File: rtl/fixed_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready handshake.
// S1 registers operands, middle stage(s) carry the full product, the last
// stage registers the rounded/saturated result. A stalled output freezes the
// whole pipe.
module fixed_mult_pipe
    import fixed_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FRAC   = DEF_FRAC,
    parameter int STAGES = 3,
    parameter bit ROUND  = 1'b1,
    parameter bit SAT    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    fixed_mult_pipe_if.slave bus,
    input  logic             clr,
    output logic             ovf_sticky
);
    localparam int PW = 2*WIDTH;

    logic                    stall;
    logic                    in_fire;
    logic [STAGES:1]         vld_pipe;
    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic signed [PW-1:0]    p_last;
    logic [WIDTH-1:0]        y_rs;
    logic                    ovf_rs;
    logic [WIDTH-1:0]        y_r;
    logic                    ovf_r;

    assign stall         = vld_pipe[STAGES] & ~bus.out_ready;
    assign in_fire       = bus.in_valid & ~stall;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.y         = y_r;
    assign bus.ovf       = ovf_r;

    // Valid bits shift with the data and freeze on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        vld_pipe <= '0;
        else if (!stall) vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
    end

    // S1: operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
        end else if (!stall) begin
            a_r <= bus.a;
            b_r <= bus.b;
        end
    end

    generate
        if (STAGES == 2) begin : g_s2
            // No middle register: product feeds the output stage directly
            assign p_last = PW'(a_r) * PW'(b_r);
        end else if (STAGES == 3) begin : g_s3
            logic signed [PW-1:0] p_r;
            // S2: full product
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         p_r <= '0;
                else if (!stall) p_r <= PW'(a_r) * PW'(b_r);
            end
            assign p_last = p_r;
        end else begin : g_s4
            localparam int H = WIDTH / 2;
            logic [PW-1:0]        pp_hi;
            logic [PW-1:0]        pp_lo;
            logic signed [PW-1:0] p_r;
            // S2: two partial products, b split into signed high and unsigned low half
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pp_hi <= '0;
                    pp_lo <= '0;
                end else if (!stall) begin
                    pp_hi <= PW'(a_r) * PW'($signed(b_r[WIDTH-1:H]));
                    pp_lo <= PW'(a_r) * PW'({1'b0, b_r[H-1:0]});
                end
            end
            // S3: recombine partials into the full product (mod 2^PW is exact)
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         p_r <= '0;
                else if (!stall) p_r <= (pp_hi << H) + pp_lo;
            end
            assign p_last = p_r;
        end
    endgenerate

    fixed_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_round_sat (
        .p   (p_last),
        .y   (y_rs),
        .ovf (ovf_rs)
    );

    // Output stage loads only real items so y/ovf hold across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r   <= '0;
            ovf_r <= 1'b0;
        end else if (!stall && vld_pipe[STAGES-1]) begin
            y_r   <= y_rs;
            ovf_r <= ovf_rs;
        end
    end

    // Sticky overflow: set on an accepted overflowing result, clr has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           ovf_sticky <= 1'b0;
        else if (clr)                                      ovf_sticky <= 1'b0;
        else if (vld_pipe[STAGES] && bus.out_ready && ovf_r) ovf_sticky <= 1'b1;
    end
endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Bench for fixed_mult_pipe: directed vector table on the default and the
// truncate/wrap configurations, hand sequences for sticky/clr, backpressure
// and reset, then random streams against a wide-integer reference model.
module tb_fixed_mult_pipe;
    import fixed_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic stk_m, stk_t, stk_2, stk_4, stk_16;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_stk_m = 1'b0;
    logic exp_stk_t = 1'b0;

    always #5 clk = ~clk;

    fixed_mult_pipe_if #(.WIDTH(32)) m();
    fixed_mult_pipe_if #(.WIDTH(32)) t();
    fixed_mult_pipe_if #(.WIDTH(32)) s2();
    fixed_mult_pipe_if #(.WIDTH(32)) s4();
    fixed_mult_pipe_if #(.WIDTH(16)) w16();

    fixed_mult_pipe #(.WIDTH(32), .FRAC(16), .STAGES(3), .ROUND(1'b1), .SAT(1'b1))
        dut   (.clk(clk), .rst(rst), .bus(m),   .clr(clr), .ovf_sticky(stk_m));
    fixed_mult_pipe #(.WIDTH(32), .FRAC(16), .STAGES(3), .ROUND(1'b0), .SAT(1'b0))
        dut_t (.clk(clk), .rst(rst), .bus(t),   .clr(clr), .ovf_sticky(stk_t));
    fixed_mult_pipe #(.WIDTH(32), .FRAC(16), .STAGES(2), .ROUND(1'b1), .SAT(1'b1))
        dut_2 (.clk(clk), .rst(rst), .bus(s2),  .clr(clr), .ovf_sticky(stk_2));
    fixed_mult_pipe #(.WIDTH(32), .FRAC(16), .STAGES(4), .ROUND(1'b1), .SAT(1'b1))
        dut_4 (.clk(clk), .rst(rst), .bus(s4),  .clr(clr), .ovf_sticky(stk_4));
    fixed_mult_pipe #(.WIDTH(16), .FRAC(8),  .STAGES(3), .ROUND(1'b1), .SAT(1'b1))
        dut_16(.clk(clk), .rst(rst), .bus(w16), .clr(clr), .ovf_sticky(stk_16));

    typedef struct {
        q16_16_t a;
        q16_16_t b;
        q16_16_t y_rs;   // ROUND=1, SAT=1
        logic    o_rs;
        q16_16_t y_ts;   // ROUND=0, SAT=0
        logic    o_ts;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    logic [32:0] sbq[4][$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: 128-bit integer arithmetic, returns {ovf, y zero-extended}
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input int f,
                                          input bit rnd, input bit sat);
        logic signed [127:0] pa, pb, p, r, mx, mn;
        logic [31:0] y;
        logic o;
        pa = $signed({96'd0, a});
        pb = $signed({96'd0, b});
        pa = (pa <<< (128 - w)) >>> (128 - w);
        pb = (pb <<< (128 - w)) >>> (128 - w);
        p  = pa * pb;
        if (rnd) p = p + (128'sd1 <<< (f - 1));
        r  = p >>> f;
        mx = (128'sd1 <<< (w - 1)) - 128'sd1;
        mn = -(128'sd1 <<< (w - 1));
        o  = (r > mx) || (r < mn);
        if (o && sat) r = (r > mx) ? mx : mn;
        y = r[31:0];
        if (w < 32) y = y & ((32'd1 << w) - 32'd1);
        return {o, y};
    endfunction

    function automatic logic [31:0] rop();
        logic signed [31:0] v;
        v = $signed($urandom);
        return v >>> $urandom_range(0, 28);
    endfunction

    task automatic sb(input int k, input bit in_f, input logic [31:0] a, input logic [31:0] b,
                      input bit out_f, input logic [32:0] act,
                      input int w, input int f, input bit r, input bit s);
        logic [32:0] e;
        if (in_f) sbq[k].push_back(model(a, b, w, f, r, s));
        if (out_f) begin
            if (sbq[k].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rnd%0d spurious: got %h expected no output", k, act);
            end else begin
                e = sbq[k].pop_front();
                check($sformatf("rnd%0d result", k), {31'd0, act}, {31'd0, e});
            end
        end
    endtask

    // One pair through the default and truncate/wrap DUTs, exact latency check
    task automatic pair(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ey, input logic eo,
                        input logic [31:0] ety, input logic eto);
        m.a = a; m.b = b; t.a = a; t.b = b;
        m.in_valid = 1'b1; t.in_valid = 1'b1;
        m.out_ready = 1'b1; t.out_ready = 1'b1;
        @(posedge clk); #1;
        m.in_valid = 1'b0; t.in_valid = 1'b0;
        @(posedge clk); #1;
        check({nm, " early"}, m.out_valid, 0);
        @(posedge clk); #1;
        check({nm, " vld"},   m.out_valid, 1);
        check({nm, " y"},     m.y, ey);
        check({nm, " ovf"},   m.ovf, eo);
        check({nm, " t.vld"}, t.out_valid, 1);
        check({nm, " t.y"},   t.y, ety);
        check({nm, " t.ovf"}, t.ovf, eto);
        exp_stk_m = exp_stk_m | eo;
        exp_stk_t = exp_stk_t | eto;
        @(posedge clk); #1;
        check({nm, " stk"},   stk_m, exp_stk_m);
        check({nm, " t.stk"}, stk_t, exp_stk_t);
        check({nm, " drained"}, m.out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, bad;
        vt[0]  = '{32'h0001_8000, 32'h0003_4000, 32'h0004_E000, 1'b0, 32'h0004_E000, 1'b0};
        vt[1]  = '{32'hFFFC_8000, 32'h0004_8000, 32'hFFF0_4000, 1'b0, 32'hFFF0_4000, 1'b0};
        vt[2]  = '{32'hFFFC_8000, 32'hFFFC_8000, 32'h000C_4000, 1'b0, 32'h000C_4000, 1'b0};
        vt[3]  = '{32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1, 32'hFFFE_0000, 1'b1};
        vt[4]  = '{32'h8000_0000, 32'h0002_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vt[5]  = '{32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0};
        vt[6]  = '{32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vt[7]  = '{32'h0001_8000, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b0};
        vt[8]  = '{32'hFFFE_8000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0};
        vt[9]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_0000, 1'b1};
        vt[10] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};
        vt[11] = '{32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0};
        vt[12] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vt[13] = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0};
        vt[14] = '{32'hFFFF_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1};

        m.in_valid = 0;  m.a = 0;  m.b = 0;  m.out_ready = 0;
        t.in_valid = 0;  t.a = 0;  t.b = 0;  t.out_ready = 0;
        s2.in_valid = 0; s2.a = 0; s2.b = 0; s2.out_ready = 0;
        s4.in_valid = 0; s4.a = 0; s4.b = 0; s4.out_ready = 0;
        w16.in_valid = 0; w16.a = 0; w16.b = 0; w16.out_ready = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", m.out_valid, 0);
        check("rst in_ready",  m.in_ready, 1);
        check("rst y",         m.y, 0);
        check("rst ovf",       m.ovf, 0);
        check("rst sticky",    stk_m, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < NV; i++)
            pair($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].y_rs, vt[i].o_rs,
                 vt[i].y_ts, vt[i].o_ts);

        // clr clears the sticky flag
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_stk_m = 1'b0; exp_stk_t = 1'b0;
        check("clr sticky",   stk_m, 0);
        check("clr t.sticky", stk_t, 0);

        // clr wins over a same-cycle overflowing output transfer
        m.a = 32'h7FFF_0000; m.b = 32'h0002_0000; m.in_valid = 1'b1; m.out_ready = 1'b1;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("clrw ovf", m.ovf, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr wins", stk_m, 0);

        // Sticky only updates on an output transfer
        m.in_valid = 1'b1; m.out_ready = 1'b0;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("held vld",        m.out_valid, 1);
        check("held in_ready",   m.in_ready, 0);
        check("no xfer no stk",  stk_m, 0);
        m.out_ready = 1'b1;
        @(posedge clk); #1;
        check("xfer sets stk",   stk_m, 1);

        // Backpressure: 10 items, out_ready low for 6 cycles
        sent = 0; got = 0; bad = 0;
        m.out_ready = 1'b0;
        m.b = 32'h0002_8000;
        for (int c = 0; c < 6; c++) begin
            m.in_valid = (sent < 10);
            m.a = (sent + 1) << 16;
            #1;
            if (m.in_valid && m.in_ready) sent++;
            @(posedge clk); #1;
        end
        check("bp accepted", sent, 3);
        check("bp in_ready", m.in_ready, 0);
        m.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            m.in_valid = (sent < 10);
            m.a = (sent + 1) << 16;
            #1;
            if (!m.out_valid) bad++;
            else begin
                check($sformatf("bp y%0d", got), m.y, (got + 1) * 32'h0002_8000);
                check($sformatf("bp ovf%0d", got), m.ovf, 0);
                got++;
            end
            if (m.in_valid && m.in_ready) sent++;
            @(posedge clk); #1;
        end
        m.in_valid = 1'b0;
        check("bp gaps", bad, 0);
        check("bp got",  got, 10);
        check("bp sent", sent, 10);
        check("bp empty", m.out_valid, 0);

        // Reset with 3 items in flight
        m.out_ready = 1'b0;
        m.b = 32'h0001_0000;
        for (int i = 0; i < 3; i++) begin
            m.a = (i + 1) << 16; m.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        m.in_valid = 1'b0;
        check("pre-rst vld", m.out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst-mid vld",      m.out_valid, 0);
        check("rst-mid in_ready", m.in_ready, 1);
        check("rst-mid y",        m.y, 0);
        check("rst-mid sticky",   stk_m, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_stk_m = 1'b0; exp_stk_t = 1'b0;
        @(posedge clk); #1;
        m.out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (m.out_valid) bad++;
            @(posedge clk); #1;
        end
        check("no stale out", bad, 0);
        pair("post-rst", 32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0,
             32'h0006_0000, 1'b0);

        // Random streams on STAGES=3, 2, 4 and WIDTH=16/FRAC=8
        for (int c = 0; c < 2000; c++) begin
            m.in_valid   = ($urandom_range(0, 3) != 0); m.a = rop(); m.b = rop();
            m.out_ready  = ($urandom_range(0, 3) != 0);
            s2.in_valid  = ($urandom_range(0, 3) != 0); s2.a = rop(); s2.b = rop();
            s2.out_ready = ($urandom_range(0, 3) != 0);
            s4.in_valid  = ($urandom_range(0, 3) != 0); s4.a = rop(); s4.b = rop();
            s4.out_ready = ($urandom_range(0, 3) != 0);
            w16.in_valid = ($urandom_range(0, 3) != 0); w16.a = 16'(rop()); w16.b = 16'(rop());
            w16.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            sb(0, m.in_valid && m.in_ready, m.a, m.b, m.out_valid && m.out_ready,
               {m.ovf, m.y}, 32, 16, 1'b1, 1'b1);
            sb(1, s2.in_valid && s2.in_ready, s2.a, s2.b, s2.out_valid && s2.out_ready,
               {s2.ovf, s2.y}, 32, 16, 1'b1, 1'b1);
            sb(2, s4.in_valid && s4.in_ready, s4.a, s4.b, s4.out_valid && s4.out_ready,
               {s4.ovf, s4.y}, 32, 16, 1'b1, 1'b1);
            sb(3, w16.in_valid && w16.in_ready, 32'(w16.a), 32'(w16.b),
               w16.out_valid && w16.out_ready, {w16.ovf, 16'd0, w16.y}, 16, 8, 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        m.in_valid = 0; s2.in_valid = 0; s4.in_valid = 0; w16.in_valid = 0;
        m.out_ready = 1; s2.out_ready = 1; s4.out_ready = 1; w16.out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            #1;
            sb(0, 1'b0, 0, 0, m.out_valid,   {m.ovf, m.y},   32, 16, 1'b1, 1'b1);
            sb(1, 1'b0, 0, 0, s2.out_valid,  {s2.ovf, s2.y}, 32, 16, 1'b1, 1'b1);
            sb(2, 1'b0, 0, 0, s4.out_valid,  {s4.ovf, s4.y}, 32, 16, 1'b1, 1'b1);
            sb(3, 1'b0, 0, 0, w16.out_valid, {w16.ovf, 16'd0, w16.y}, 16, 8, 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("rnd%0d leftover", k), sbq[k].size(), 0);

        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("final clr s2",  stk_2, 0);
        check("final clr s4",  stk_4, 0);
        check("final clr w16", stk_16, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fixed_mult_pipe.md
Name: fixed_mult_pipe

Overview:
Pipelined, parametrised signed fixed-point multiplier for the AM receiver datapath. It is the successor to the combinational Q16.16 multiplier. It adds a configurable Q format, selectable rounding or truncation, and saturation with overflow flags. A valid/ready handshake with full-pipeline backpressure lets it sit between the mixer/NCO stage and the low-pass filter.

Parameters:
WIDTH, 32, total operand/result width in bits (two's complement), 8..32
FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC), 1..WIDTH-1
STAGES, 3, pipeline latency in cycles, 2..4
ROUND, 1, 1 = round half toward +inf, 0 = truncate (floor)
SAT, 1, 1 = saturate to signed range, 0 = wrap (keep low WIDTH bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair a/b valid
in_ready  out  1  block can accept operands this cycle
a  in  WIDTH  signed fixed-point operand
b  in  WIDTH  signed fixed-point operand
out_valid  out  1  result y valid
out_ready  in  1  downstream accepts y this cycle
y  out  WIDTH  signed fixed-point product
ovf  out  1  result was out of range (valid with out_valid)
ovf_sticky  out  1  set by any accepted overflowing result; cleared by clr
clr  in  1  synchronous clear of ovf_sticky (clr wins over a same-cycle set)

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0, out_valid=0, y=0, ovf=0, ovf_sticky=0. in_ready=1 after reset.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - On stall, every stage holds its data and valid bits. No bubble collapsing is required.
- Latency and throughput: an operand accepted at cycle t appears on y at cycle t+STAGES if there are no stalls. Throughput is 1 result/cycle. Order is preserved.
- Stages:
  - S1 registers a, b.
  - Middle stage(s) compute and carry the full 2*WIDTH signed product. With STAGES=4 the product is split across two registers.
  - The last stage registers the round/saturate output and ovf.
- Arithmetic:
  - p = a*b as a 2*WIDTH signed value, scaled 2^-2FRAC.
  - ROUND=1: p' = p + 2^(FRAC-1). ROUND=0: p' = p.
  - r = p' >>> FRAC (arithmetic shift).
  - Overflow when r > 2^(WIDTH-1)-1 or r < -2^(WIDTH-1).
  - On overflow: SAT=1 gives y = max 0x7F..F or min 0x80..0; SAT=0 gives y = r[WIDTH-1:0].
  - ovf=1 in both modes on overflow.
  - The rounding add must not itself wrap; compute it with one guard bit.
- ovf_sticky updates only on an output transfer.
- Bubbles: invalid stage data is don't-care. y and ovf retain their last value while out_valid=0.
- Reset mid-operation: in-flight operands are discarded and no spurious out_valid appears after reset.
- Simultaneous in and out transfer while full: both occur and the occupancy is unchanged.

Decomposition:
- Package fixed_pkg:
  - default WIDTH/FRAC localparams
  - typedef for the Q16.16 word
  - function/constants for signed max/min of WIDTH
- Sub-module fixed_round_sat:
  - combinational; parameters WIDTH, FRAC, ROUND, SAT
  - input 2*WIDTH product; outputs y, ovf
  - instantiated in the last stage and unit-testable alone

Test Plan (WIDTH=32, FRAC=16, ROUND=1, SAT=1, STAGES=3 unless noted):
- a=0x0001_8000 (1.5), b=0x0003_4000 (3.25) -> y=0x0004_E000 (4.875) three cycles later, ovf=0. Then a=0xFFFC_8000 (-3.5), b=0x0004_8000 (4.5) -> y=0xFFF0_4000 (-15.75). Then a=b=0xFFFC_8000 -> y=0x000C_4000 (12.25).
- a=0x7FFF_0000, b=0x0002_0000 -> y=0x7FFF_FFFF, ovf=1, ovf_sticky=1. a=0x8000_0000, b=0x0002_0000 -> y=0x8000_0000, ovf=1. With SAT=0, the first pair gives y=0xFFFE_0000, ovf=1. Then clr=1 gives ovf_sticky=0.
- Rounding, with ROUND=1:
  - a=0x0000_0001, b=0x0000_8000 -> y=0x0000_0001.
  - a=0xFFFF_FFFF, b=0x0000_8000 -> y=0x0000_0000.
  - With ROUND=0, the same pairs give y=0x0000_0000 and 0xFFFF_FFFF.
- Backpressure:
  - Stream 10 consecutive operands with out_ready=0 for 6 cycles -> in_ready drops after 3 accepted.
  - Raise out_ready -> all 10 products emerge in order, none lost or duplicated, one per cycle.
- Assert rst for one cycle with 3 items in flight -> out_valid=0 immediately. No stale result appears afterwards, and the next accepted pair emerges after exactly STAGES cycles.
- Random back-to-back stream (1000 pairs, random in_valid/out_ready) vs. a reference model, repeated for STAGES=2 and 4 and for WIDTH=16, FRAC=8 -> all results and ovf bits match.
